bf_mem: RTL

- Parametrised single-port synchronous data/program memory for the bf8b core.
- Replaces the bare one-cycle bench memory with an RTL block that has:
  - a req/ack handshake to the CPU;
  - configurable wait states;
  - write-first semantics;
  - a sequential byte-stream loader for preloading programs.
- Sits between the core's memory bus and the program source (bench or UART).

---
 rtl/bf_mem_pkg.sv | 14 +
 rtl/bf_mem_array.sv | 24 ++
 rtl/bf_mem.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bf_mem_pkg.sv
// Shared types and constants for the bf8b memory block.
package bf_mem_pkg;

  localparam int WAIT_W   = 4;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } state_t;

endpackage

// File: rtl/bf_mem_array.sv
// DEPTH x DATA_W storage: synchronous write, combinational read, no reset.
module bf_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bf_mem.sv
// bf8b data/program memory: CPU req/ack port with wait states, plus a
// sequential byte-stream loader that fills the array from address 0.
//
// state | meaning
// IDLE  | waiting; load_req wins over cpu_req
// LOAD  | accepting loader beats into the array at the load pointer
// WAIT  | counting WAIT_STATES cycles after a CPU access was accepted
// ACK   | one-cycle completion, cpu_rdata valid
module bf_mem
  import bf_mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
);

  localparam logic [WAIT_W-1:0] WS       = WAIT_W'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  if (WAIT_STATES > MAX_WAIT || WAIT_STATES < 0) begin : g_ws_check
    $fatal(1, "bf_mem: WAIT_STATES must be in 0..15");
  end

  state_t            state, state_nx;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] ptr;
  logic [WAIT_W-1:0] wcnt;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;

  logic              accept;
  logic              xfer;
  logic              load_end;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [ADDR_W-1:0] arr_raddr;
  logic [DATA_W-1:0] arr_rdata;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] fwd_data;

  assign accept   = (state == IDLE) && !load_req && cpu_req;
  assign xfer     = (state == LOAD) && load_valid;
  assign load_end = xfer && (load_last || (ptr == LAST_PTR));

  // CPU writes commit at the acceptance edge; loader beats at each transfer.
  assign arr_we    = (accept && cpu_we) || xfer;
  assign arr_waddr = (state == LOAD) ? ptr : cpu_addr;
  assign arr_wdata = (state == LOAD) ? load_data : cpu_wdata;
  assign arr_raddr = (state == IDLE) ? cpu_addr : lat_addr;

  bf_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  // With no wait states the write lands on the same edge rdata is captured,
  // so write data is forwarded instead of reading the array back.
  assign sel_we    = (state == IDLE) ? cpu_we : lat_we;
  assign sel_wdata = (state == IDLE) ? cpu_wdata : lat_wdata;
  assign fwd_data  = sel_we ? sel_wdata : arr_rdata;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (load_req)     state_nx = LOAD;
        else if (cpu_req) state_nx = (WS == '0) ? ACK : WAIT;
      end
      LOAD: if (load_end) state_nx = IDLE;
      WAIT: if (wcnt == WS) state_nx = ACK;
      ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ptr       <= '0;
      wcnt      <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= load_end;

      if (accept) begin
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
      end

      if ((state == IDLE) && load_req) ptr <= '0;
      else if (xfer)                   ptr <= ptr + 1'b1;

      if (accept && (WS != '0))        wcnt <= WAIT_W'(1);
      else if (state == WAIT)          wcnt <= (wcnt == WS) ? '0 : wcnt + 1'b1;

      if (state_nx == ACK) rdata_q <= fwd_data;
    end
  end

  assign cpu_ack    = (state == ACK);
  assign cpu_rdata  = rdata_q;
  assign load_ready = (state == LOAD);
  assign load_done  = done_q;
  assign busy       = (state != IDLE);

endmodule
